// File: rtl/fifo_status_ctrl_pkg.sv
// Shared sync-FIFO build switches, wrap constant and status type.
// Macros: FIFO_DEPTH (default depth), FIFO_PTR_INC (wrap compare), FIFO_STATUS_ERR_EN (sticky error flags).
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 8
`endif
`ifndef FIFO_PTR_INC
`define FIFO_PTR_INC(depth) ((depth) - 1)
`endif

package fifo_status_ctrl_pkg;

  typedef struct packed {
    logic full;
    logic almostfull;
    logic empty;
    logic almostempty;
  } status_t;

  localparam status_t STATUS_RST = '{full: 1'b0, almostfull: 1'b0, empty: 1'b1, almostempty: 1'b1};

  // Last valid index before wrapping; shared with the RAM wrapper.
  function automatic int unsigned ptr_last(input int unsigned depth);
    return `FIFO_PTR_INC(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// FIFO address pointer: advances on inc, wraps explicitly at FIFO_DEPTH-1 so any depth >= 2 works.
module fifo_ptr_wrap
  import fifo_status_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = `FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ptr_last(FIFO_DEPTH));

  logic [ADDR_WIDTH-1:0] r_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + ADDR_WIDTH'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/fifo_status_ctrl.sv
// Sync FIFO control/status: pointers, occupancy and registered flags, all derived from the next count.
// Optional sticky overflow/underflow flags when FIFO_STATUS_ERR_EN is defined.
module fifo_status_ctrl
  import fifo_status_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = `FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_valid_s,
  output logic                  o_ready_s,
  input  logic                  i_ready_m,
  output logic                  o_valid_m,
  input  logic [ADDR_WIDTH-1:0] i_almostfull_lvl,
  input  logic [ADDR_WIDTH-1:0] i_almostempty_lvl,
  input  logic                  i_err_clr,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_full,
  output logic                  o_almostfull,
  output logic                  o_empty,
  output logic                  o_almostempty,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam logic [CNT_WIDTH:0]   DEPTH_X = (CNT_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);

  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic [CNT_WIDTH:0]   w_free_nxt;
  status_t              w_stat_nxt;
  logic [CNT_WIDTH-1:0] r_count;
  status_t              r_stat;

  assign w_wr_acc = i_valid_s & ~r_stat.full;
  assign w_rd_acc = i_ready_m & ~r_stat.empty;

  assign w_count_nxt = r_count + CNT_WIDTH'(w_wr_acc) - CNT_WIDTH'(w_rd_acc);

  // Extra bit keeps the free-slot subtraction from wrapping.
  always_comb begin
    w_free_nxt             = DEPTH_X - {1'b0, w_count_nxt};
    w_stat_nxt             = STATUS_RST;
    w_stat_nxt.full        = (w_count_nxt == DEPTH_C);
    w_stat_nxt.empty       = (w_count_nxt == '0);
    w_stat_nxt.almostfull  = (w_free_nxt <= (CNT_WIDTH + 1)'(i_almostfull_lvl));
    w_stat_nxt.almostempty = (w_count_nxt <= CNT_WIDTH'(i_almostempty_lvl));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_stat  <= STATUS_RST;
    end else begin
      r_count <= w_count_nxt;
      r_stat  <= w_stat_nxt;
    end
  end

  fifo_ptr_wrap #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_wr_acc),
    .ptr     (o_wr_addr)
  );

  fifo_ptr_wrap #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_rd_acc),
    .ptr     (o_rd_addr)
  );

`ifdef FIFO_STATUS_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_err_clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_valid_s & r_stat.full)  r_overflow  <= 1'b1;
      if (i_ready_m & r_stat.empty) r_underflow <= 1'b1;
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = i_err_clr;
  assign o_overflow       = 1'b0;
  assign o_underflow      = 1'b0;
`endif

  assign o_wr_en       = w_wr_acc;
  assign o_rd_en       = w_rd_acc;
  assign o_ready_s     = ~r_stat.full;
  assign o_valid_m     = ~r_stat.empty;
  assign o_count       = r_count;
  assign o_full        = r_stat.full;
  assign o_almostfull  = r_stat.almostfull;
  assign o_empty       = r_stat.empty;
  assign o_almostempty = r_stat.almostempty;

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// Bench for fifo_status_ctrl at depth 6: queue-based occupancy model checked every cycle,
// directed boundary cases with literal expectations, then randomized traffic with a mid-run reset.
module tb_fifo_status_ctrl;
  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int CW    = 4;
`ifdef FIFO_STATUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_valid_s = 1'b0;
  logic          i_ready_m = 1'b0;
  logic          i_err_clr = 1'b0;
  logic [AW-1:0] i_almostfull_lvl = 3'd1;
  logic [AW-1:0] i_almostempty_lvl = 3'd1;
  logic          o_ready_s, o_valid_m, o_wr_en, o_rd_en;
  logic [AW-1:0] o_wr_addr, o_rd_addr;
  logic [CW-1:0] o_count;
  logic          o_full, o_almostfull, o_empty, o_almostempty, o_overflow, o_underflow;

  always #5 clk = ~clk;

  fifo_status_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_valid_s         (i_valid_s),
    .o_ready_s         (o_ready_s),
    .i_ready_m         (i_ready_m),
    .o_valid_m         (o_valid_m),
    .i_almostfull_lvl  (i_almostfull_lvl),
    .i_almostempty_lvl (i_almostempty_lvl),
    .i_err_clr         (i_err_clr),
    .o_wr_en           (o_wr_en),
    .o_wr_addr         (o_wr_addr),
    .o_rd_en           (o_rd_en),
    .o_rd_addr         (o_rd_addr),
    .o_count           (o_count),
    .o_full            (o_full),
    .o_almostfull      (o_almostfull),
    .o_empty           (o_empty),
    .o_almostempty     (o_almostempty),
    .o_overflow        (o_overflow),
    .o_underflow       (o_underflow)
  );

  // Model: queue of slot addresses currently held, next write slot, registered flags.
  int mq[$];
  int m_wr;
  bit m_af, m_ae, m_ovf, m_unf;
  bit chk_en = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wr  = 0;
    m_af  = 1'b0;
    m_ae  = 1'b1;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_update();
    int sz;
    bit wa, ra;
    if (reset_n) begin
      sz = mq.size();
      wa = i_valid_s && (sz < DEPTH);
      ra = i_ready_m && (sz > 0);
      if (ERR_EN) begin
        if (i_err_clr) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end else begin
          if (i_valid_s && sz == DEPTH) m_ovf = 1'b1;
          if (i_ready_m && sz == 0)     m_unf = 1'b1;
        end
      end
      if (ra) void'(mq.pop_front());
      if (wa) begin
        mq.push_back(m_wr);
        m_wr = (m_wr + 1) % DEPTH;
      end
      sz   = mq.size();
      m_af = (DEPTH - sz) <= int'(i_almostfull_lvl);
      m_ae = sz <= int'(i_almostempty_lvl);
    end
  endtask

  always @(negedge clk) begin : compare
    int sz;
    if (chk_en) begin
      sz = mq.size();
      chk("count",       o_count, sz);
      chk("full",        o_full, sz == DEPTH);
      chk("empty",       o_empty, sz == 0);
      chk("almostfull",  o_almostfull, m_af);
      chk("almostempty", o_almostempty, m_ae);
      chk("ready_s",     o_ready_s, sz != DEPTH);
      chk("valid_m",     o_valid_m, sz != 0);
      chk("wr_en",       o_wr_en, i_valid_s && sz < DEPTH);
      chk("rd_en",       o_rd_en, i_ready_m && sz > 0);
      chk("wr_addr",     o_wr_addr, m_wr);
      chk("rd_addr",     o_rd_addr, (sz > 0) ? mq[0] : m_wr);
      chk("overflow",    o_overflow, m_ovf);
      chk("underflow",   o_underflow, m_unf);
    end
  end

  task automatic drive(input logic v, input logic r, input logic c);
    i_valid_s = v;
    i_ready_m = r;
    i_err_clr = c;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    drive(0, 0, 0);
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_almostempty", o_almostempty, 1);
    chk("rst_ready_s", o_ready_s, 1);
    chk("rst_valid_m", o_valid_m, 0);
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0);
      chk("fill_wr_addr", o_wr_addr, i);
      chk("fill_count", o_count, i);
      chk("fill_almostfull", o_almostfull, i >= 5);
      tick();
    end
    drive(1, 0, 0);
    chk("full_count", o_count, 6);
    chk("full_flag", o_full, 1);
    chk("full_wr_blocked", o_wr_en, 0);
    tick();

    if (ERR_EN) begin
      drive(0, 0, 0);
      chk("ovf_set", o_overflow, 1);
      tick();
      drive(1, 0, 1);
      tick();
      drive(0, 0, 0);
      chk("ovf_clr_wins", o_overflow, 0);
      tick();
    end

    drive(1, 1, 0);
    chk("full_both_rd_en", o_rd_en, 1);
    chk("full_both_wr_en", o_wr_en, 0);
    tick();
    drive(0, 0, 0);
    chk("after_full_count", o_count, 5);
    chk("after_full_full", o_full, 0);
    chk("after_full_af", o_almostfull, 1);
    tick();

    repeat (5) begin
      drive(0, 1, 0);
      tick();
    end
    drive(1, 1, 0);
    chk("empty_both_rd_en", o_rd_en, 0);
    chk("empty_both_wr_en", o_wr_en, 1);
    tick();
    drive(0, 0, 1);
    chk("after_empty_count", o_count, 1);
    chk("after_empty_empty", o_empty, 0);
    tick();

    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0);
      tick();
      drive(0, 1, 0);
      tick();
    end

    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        i_almostfull_lvl  = AW'($urandom_range(0, 7));
        i_almostempty_lvl = AW'($urandom_range(0, 7));
      end
      if (i == 1500) begin
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_count", o_count, 0);
        chk("midrst_empty", o_empty, 1);
        chk("midrst_wr_addr", o_wr_addr, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
      end
      drive(logic'($urandom_range(0, 3) < (((i / 40) % 2 == 1) ? 3 : 1)),
            logic'($urandom_range(0, 3) < (((i / 40) % 2 == 1) ? 1 : 3)),
            logic'($urandom_range(0, 31) == 0));
      tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
